// File: rtl/cdmesh_e2e_demo_pkg.sv
// rtl/cdmesh_e2e_demo_pkg.sv - shared header layout, burst and LLC constants
package cdmesh_e2e_demo_pkg;

    localparam int VC_BIT         = 63;
    localparam int DX_BIT         = 62;
    localparam int DY_BIT         = 61;
    localparam int REPLY_FLAG_BIT = 60;
    localparam int BEAT_BIT       = 56;
    localparam int HX_LSB         = 52;
    localparam int HX_W           = 4;
    localparam int HY_LSB         = 48;
    localparam int SRCX_LSB       = 40;
    localparam int SRCX_W         = 8;
    localparam int SRCY_LSB       = 32;

    localparam int BURST          = 2;
    localparam int NUM_ROUTERS    = 4;
    localparam int NUM_LLC        = 2;
    localparam int LLC0_X         = 0;
    localparam int LLC1_X         = 3;
    localparam int HX_LLC1_MIN    = 2;

    typedef enum logic {
        PX_IDLE = 1'b0,
        PX_BUSY = 1'b1
    } px_state_t;

    // Requests heading to the east half of the row are served by the LLC at X=3.
    function automatic logic sel_llc1(input logic [HX_W-1:0] hx);
        return hx >= HX_W'(HX_LLC1_MIN);
    endfunction

endpackage

// File: rtl/cdmesh_e2e_demo_llc.sv
// rtl/cdmesh_e2e_demo_llc.sv - LLC proxy: latches one request, replies with a fixed burst
module llc_proxy
    import cdmesh_e2e_demo_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_tvalid,
    input  logic [DATA_W-1:0] req_tdata,
    output logic              idle,
    output logic              rsp_tvalid,
    input  logic              rsp_tready,
    output logic [DATA_W-1:0] rsp_tdata,
    output logic [1:0]        rsp_dest
);

    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

    px_state_t         state_q, state_d;
    logic [BW-1:0]     beat_q;
    logic [DATA_W-1:0] lat_q;
    logic              last_beat;

    assign last_beat = (beat_q == BW'(BURST - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= PX_IDLE;
        else       state_q <= state_d;
    end

    // Next state: leave IDLE on a grant, return once the final beat is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PX_IDLE: if (req_tvalid) state_d = PX_BUSY;
            PX_BUSY: if (rsp_tready && last_beat) state_d = PX_IDLE;
            default: state_d = PX_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        idle       = (state_q == PX_IDLE);
        rsp_tvalid = (state_q == PX_BUSY);
    end

    // Request latch and beat counter; the counter only moves on an accepted beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_q  <= '0;
            beat_q <= '0;
        end else if (state_q == PX_IDLE && req_tvalid) begin
            lat_q  <= req_tdata;
            beat_q <= '0;
        end else if (rsp_tvalid && rsp_tready) begin
            beat_q <= last_beat ? '0 : beat_q + 1'b1;
        end
    end

    // Reply beat: the request with the reply flag raised and the beat index stamped in.
    always_comb begin
        rsp_tdata                 = lat_q;
        rsp_tdata[REPLY_FLAG_BIT] = 1'b1;
        rsp_tdata[BEAT_BIT]       = beat_q[0];
        rsp_dest                  = lat_q[SRCX_LSB +: 2];
    end

endmodule

// File: rtl/cdmesh_e2e_demo.sv
// rtl/cdmesh_e2e_demo.sv - 1x4 mesh row demo: inject buffers, LLC arbiters, output buffers
module cdmesh_e2e_demo
    import cdmesh_e2e_demo_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            l0_in_si,
    output logic [3:0]            l0_in_ri,
    input  logic [4*DATA_W-1:0]   l0_in_di,
    output logic [3:0]            l0_out_so,
    input  logic [3:0]            l0_out_ro,
    output logic [4*DATA_W-1:0]   l0_out_do
);

    logic [3:0]          g_in_si;
    logic [3:0]          l0_cv_so;
    logic [3:0]          l0_cv_ro;
    logic [1:0]          llc_ro;
    logic [1:0]          llc_so;
    logic [4*DATA_W-1:0] cv_do;
    logic [3:0]          tgt1;
    logic [1:0]          llc_gnt;
    logic [1:0]          llc_rdy;
    logic [1:0]          claimed;
    logic [3:0]          out_rdy;
    logic [DATA_W-1:0]   gnt_do  [NUM_LLC];
    logic [DATA_W-1:0]   rsp_do  [NUM_LLC];
    logic [1:0]          rsp_dst [NUM_LLC];

    assign l0_in_ri = ~l0_cv_so;
    assign g_in_si  = l0_in_si & l0_in_ri;
    assign out_rdy  = ~l0_out_so | l0_out_ro;

    // Single-entry inject buffers; a grant frees the entry on the same edge the proxy latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            l0_cv_so <= '0;
            cv_do    <= '0;
        end else begin
            for (int i = 0; i < NUM_ROUTERS; i++) begin
                if (g_in_si[i]) begin
                    l0_cv_so[i]               <= 1'b1;
                    cv_do[i*DATA_W +: DATA_W] <= l0_in_di[i*DATA_W +: DATA_W];
                end else if (l0_cv_ro[i]) begin
                    l0_cv_so[i] <= 1'b0;
                end
            end
        end
    end

    // Target LLC per buffered request.
    always_comb begin
        for (int i = 0; i < NUM_ROUTERS; i++)
            tgt1[i] = sel_llc1(cv_do[i*DATA_W + HX_LSB +: HX_W]);
    end

    // Per-LLC fixed-priority arbiter: the lowest full buffer claims its LLC, granted only when idle.
    always_comb begin
        l0_cv_ro  = '0;
        llc_gnt   = '0;
        claimed   = '0;
        gnt_do[0] = '0;
        gnt_do[1] = '0;
        for (int i = 0; i < NUM_ROUTERS; i++) begin
            if (l0_cv_so[i] && !claimed[tgt1[i]]) begin
                claimed[tgt1[i]] = 1'b1;
                if (llc_ro[tgt1[i]]) begin
                    l0_cv_ro[i]      = 1'b1;
                    llc_gnt[tgt1[i]] = 1'b1;
                    gnt_do[tgt1[i]]  = cv_do[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    llc_proxy #(.DATA_W(DATA_W)) u_llc0 (
        .clk        (clk),
        .reset      (reset),
        .req_tvalid (llc_gnt[0]),
        .req_tdata  (gnt_do[0]),
        .idle       (llc_ro[0]),
        .rsp_tvalid (llc_so[0]),
        .rsp_tready (llc_rdy[0]),
        .rsp_tdata  (rsp_do[0]),
        .rsp_dest   (rsp_dst[0])
    );

    llc_proxy #(.DATA_W(DATA_W)) u_llc1 (
        .clk        (clk),
        .reset      (reset),
        .req_tvalid (llc_gnt[1]),
        .req_tdata  (gnt_do[1]),
        .idle       (llc_ro[1]),
        .rsp_tvalid (llc_so[1]),
        .rsp_tready (llc_rdy[1]),
        .rsp_tdata  (rsp_do[1]),
        .rsp_dest   (rsp_dst[1])
    );

    // Reply acceptance: LLC0 has priority when both target the same output buffer.
    always_comb begin
        llc_rdy[0] = out_rdy[rsp_dst[0]];
        llc_rdy[1] = out_rdy[rsp_dst[1]] && !(llc_so[0] && rsp_dst[0] == rsp_dst[1]);
    end

    // Single-entry output buffers, refilled on the same edge they pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            l0_out_so <= '0;
            l0_out_do <= '0;
        end else begin
            for (int j = 0; j < NUM_ROUTERS; j++) begin
                if (out_rdy[j]) begin
                    if (llc_so[0] && rsp_dst[0] == 2'(j)) begin
                        l0_out_so[j]                  <= 1'b1;
                        l0_out_do[j*DATA_W +: DATA_W] <= rsp_do[0];
                    end else if (llc_so[1] && rsp_dst[1] == 2'(j)) begin
                        l0_out_so[j]                  <= 1'b1;
                        l0_out_do[j*DATA_W +: DATA_W] <= rsp_do[1];
                    end else begin
                        l0_out_so[j] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cdmesh_e2e_demo.sv
// tb/tb_cdmesh_e2e_demo.sv - self-checking bench for cdmesh_e2e_demo
module tb_cdmesh_e2e_demo;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   l0_in_si;
    logic [3:0]   l0_in_ri;
    logic [255:0] l0_in_di;
    logic [3:0]   l0_out_so;
    logic [3:0]   l0_out_ro;
    logic [255:0] l0_out_do;

    cdmesh_e2e_demo #(.DATA_W(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .l0_in_si  (l0_in_si),
        .l0_in_ri  (l0_in_ri),
        .l0_in_di  (l0_in_di),
        .l0_out_so (l0_out_so),
        .l0_out_ro (l0_out_ro),
        .l0_out_do (l0_out_do)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  r;
        logic [63:0] d;
        logic [31:0] c;
    } ent_t;

    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    ent_t        rx[$];
    ent_t        ex[$];
    logic [63:0] req_v [4];

    always @(posedge clk) cyc <= cyc + 1;

    // Log every beat consumed by the bench side of the output ports.
    always @(negedge clk) begin
        if (!reset) begin
            for (int j = 0; j < 4; j++) begin
                if (l0_out_so[j] && l0_out_ro[j])
                    rx.push_back('{r: 2'(j), d: l0_out_do[j*64 +: 64], c: 32'(cyc)});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reply beat k: reply flag at bit 60 set, bit 56 equal to k, everything else copied.
    function automatic logic [63:0] exp_beat(input logic [63:0] req, input int k);
        return (req & ~64'h0100_0000_0000_0000) | 64'h1000_0000_0000_0000
               | ((k != 0) ? 64'h0100_0000_0000_0000 : 64'h0);
    endfunction

    function automatic logic [63:0] mk_req(input int hx, input int dest);
        logic [63:0] r;
        r = {$urandom, $urandom};
        r[55:52] = 4'(hx);
        r[41:40] = 2'(dest);
        return r;
    endfunction

    function automatic int cnt(input int r);
        int n = 0;
        foreach (rx[k]) if (rx[k].r == 2'(r)) n++;
        return n;
    endfunction

    function automatic ent_t nth(input int r, input int k);
        int n = 0;
        foreach (rx[m]) begin
            if (rx[m].r == 2'(r)) begin
                if (n == k) return rx[m];
                n++;
            end
        end
        return '0;
    endfunction

    task automatic send(input logic [3:0] mask, output int t);
        l0_in_si = mask;
        for (int i = 0; i < 4; i++) l0_in_di[i*64 +: 64] = req_v[i];
        tick();
        t = cyc;
        l0_in_si = '0;
    endtask

    task automatic wait_n(input int r, input int n, input int budget);
        int b = 0;
        while (cnt(r) < n && b < budget) begin
            tick();
            b++;
        end
    endtask

    initial begin
        int          t;
        logic [3:0]  mask;
        int          found;
        logic [63:0] b0;

        reset     = 1'b1;
        l0_in_si  = '0;
        l0_in_di  = '0;
        l0_out_ro = 4'hF;
        repeat (3) tick();

        check("rst in_ri", 64'(l0_in_ri), 64'hF);
        check("rst out_so", 64'(l0_out_so), 64'h0);
        check("rst out_do", 64'(|l0_out_do), 64'h0);
        check("rst llc_ro", 64'(dut.llc_ro), 64'h3);
        check("rst llc_so", 64'(dut.llc_so), 64'h0);
        reset = 1'b0;
        tick();

        // Single request from router 0 to LLC0.
        rx.delete();
        req_v[0] = mk_req(0, 0);
        req_v[0][31:0] = 32'hDEAD_0000;
        send(4'b0001, t);
        check("single ri busy", 64'(l0_in_ri[0]), 64'h0);
        tick();
        check("single ri free", 64'(l0_in_ri[0]), 64'h1);
        wait_n(0, 2, 20);
        repeat (4) tick();
        check("single cnt", 64'(cnt(0)), 64'd2);
        check("single lat0", 64'(nth(0, 0).c), 64'(t + 2));
        check("single lat1", 64'(nth(0, 1).c), 64'(t + 3));
        check("single d0", nth(0, 0).d, exp_beat(req_v[0], 0));
        check("single d1", nth(0, 1).d, exp_beat(req_v[0], 1));
        check("single others", 64'(cnt(1) + cnt(2) + cnt(3)), 64'd0);

        // Parallel requests to different LLCs.
        rx.delete();
        req_v[0] = mk_req($urandom_range(0, 1), 0);
        req_v[1] = mk_req($urandom_range(2, 15), 1);
        send(4'b0011, t);
        wait_n(1, 2, 20);
        wait_n(0, 2, 20);
        repeat (4) tick();
        for (int r = 0; r < 2; r++) begin
            check("par cnt", 64'(cnt(r)), 64'd2);
            check("par lat0", 64'(nth(r, 0).c), 64'(t + 2));
            check("par lat1", 64'(nth(r, 1).c), 64'(t + 3));
            check("par d0", nth(r, 0).d, exp_beat(req_v[r], 0));
            check("par d1", nth(r, 1).d, exp_beat(req_v[r], 1));
        end

        // Contention: three routers to LLC0 at once, served lowest index first.
        rx.delete();
        for (int i = 0; i < 3; i++) req_v[i] = mk_req($urandom_range(0, 1), i);
        send(4'b0111, t);
        wait_n(2, 2, 40);
        repeat (4) tick();
        for (int r = 0; r < 3; r++) begin
            check("cont cnt", 64'(cnt(r)), 64'd2);
            check("cont d0", nth(r, 0).d, exp_beat(req_v[r], 0));
            check("cont d1", nth(r, 1).d, exp_beat(req_v[r], 1));
        end
        check("cont first", 64'(nth(0, 0).c), 64'(t + 2));
        check("cont gap01", 64'(nth(1, 0).c - nth(0, 1).c), 64'd2);
        check("cont gap12", 64'(nth(2, 0).c - nth(1, 1).c), 64'd2);

        // Back-pressure on router 0 while beat 0 sits in the output buffer.
        rx.delete();
        req_v[0] = mk_req($urandom_range(0, 15), 0);
        send(4'b0001, t);
        tick();
        tick();
        l0_out_ro[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("bp so", 64'(l0_out_so[0]), 64'h1);
            check("bp do", l0_out_do[63:0], exp_beat(req_v[0], 0));
            tick();
        end
        check("bp stall", 64'(|dut.llc_so), 64'h1);
        l0_out_ro[0] = 1'b1;
        wait_n(0, 2, 20);
        repeat (4) tick();
        check("bp cnt", 64'(cnt(0)), 64'd2);
        check("bp d0", nth(0, 0).d, exp_beat(req_v[0], 0));
        check("bp d1", nth(0, 1).d, exp_beat(req_v[0], 1));

        // Output collision: both LLCs reply to router 0; LLC0 goes first.
        rx.delete();
        req_v[2] = mk_req($urandom_range(0, 1), 0);
        req_v[3] = mk_req($urandom_range(2, 15), 0);
        send(4'b1100, t);
        wait_n(0, 4, 30);
        repeat (4) tick();
        check("coll cnt", 64'(cnt(0)), 64'd4);
        check("coll b0", nth(0, 0).d, exp_beat(req_v[2], 0));
        check("coll b1", nth(0, 1).d, exp_beat(req_v[2], 1));
        check("coll b2", nth(0, 2).d, exp_beat(req_v[3], 0));
        check("coll b3", nth(0, 3).d, exp_beat(req_v[3], 1));

        // Reset mid-burst, then a fresh request.
        req_v[0] = mk_req($urandom_range(0, 15), 0);
        send(4'b0001, t);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("mrst out_so", 64'(l0_out_so), 64'h0);
        check("mrst out_do", 64'(|l0_out_do), 64'h0);
        check("mrst in_ri", 64'(l0_in_ri), 64'hF);
        check("mrst llc_ro", 64'(dut.llc_ro), 64'h3);
        check("mrst llc_so", 64'(dut.llc_so), 64'h0);
        reset = 1'b0;
        tick();
        rx.delete();
        req_v[0] = mk_req($urandom_range(0, 15), 0);
        send(4'b0001, t);
        wait_n(0, 2, 20);
        repeat (6) tick();
        check("mrst cnt", 64'(cnt(0)), 64'd2);
        check("mrst d0", nth(0, 0).d, exp_beat(req_v[0], 0));
        check("mrst d1", nth(0, 1).d, exp_beat(req_v[0], 1));

        // Random soak with random back-pressure, checked as a multiset of expected beats.
        rx.delete();
        ex.delete();
        for (int c = 0; c < 300; c++) begin
            mask = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                req_v[i] = mk_req($urandom_range(0, 15), $urandom_range(0, 3));
                l0_in_di[i*64 +: 64] = req_v[i];
                if (mask[i] && l0_in_ri[i]) begin
                    ex.push_back('{r: req_v[i][41:40], d: exp_beat(req_v[i], 0), c: 32'd0});
                    ex.push_back('{r: req_v[i][41:40], d: exp_beat(req_v[i], 1), c: 32'd0});
                end
            end
            l0_in_si  = mask;
            l0_out_ro = 4'($urandom);
            tick();
        end
        l0_in_si  = '0;
        l0_out_ro = 4'hF;
        repeat (100) tick();
        foreach (rx[k]) begin
            found = -1;
            foreach (ex[m]) if (found < 0 && ex[m].r == rx[k].r && ex[m].d == rx[k].d) found = m;
            check("soak match", 64'(found >= 0), 64'h1);
            if (found >= 0) ex.delete(found);
            if (rx[k].d[56]) begin
                b0 = rx[k].d & ~64'h0100_0000_0000_0000;
                found = -1;
                foreach (ex[m]) if (ex[m].r == rx[k].r && ex[m].d == b0) found = m;
                check("soak order", 64'(found >= 0), 64'h0);
            end
        end
        check("soak left", 64'(ex.size()), 64'd0);
        check("soak idle", 64'(l0_out_so), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cdmesh_e2e_demo.md
# cdmesh_e2e_demo

End-to-end demo fabric for a 1×4 cardinal mesh row. Four routers at (0,0)..(3,0) each expose one local port. Request flits are steered to one of two LLC proxies: LLC0 at X=0, LLC1 at X=3. Each proxy answers every request with a 2-flit reply burst, which is delivered back to the local output of the router named by the request's source X field.

## Interface
- `DATA_W`, default 64: flit width. Must be ≥64 because the header layout is fixed.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `l0_in_si` input, [3:0]: per-router request valid.
- `l0_in_ri` output, [3:0]: per-router request ready.
- `l0_in_di` input, [4*DATA_W-1:0]: request flits; router i uses slice [i*DATA_W +: DATA_W].
- `l0_out_so` output, [3:0]: per-router reply valid.
- `l0_out_ro` input, [3:0]: per-router reply ready.
- `l0_out_do` output, [4*DATA_W-1:0]: reply flits, sliced the same way as `l0_in_di`.
- Internal nets that must exist with these names, for hierarchical probing:
  - `g_in_si[3:0]` = `l0_in_si & l0_in_ri`
  - `l0_cv_so[3:0]`: inject buffer valid
  - `l0_cv_ro[3:0]`: inject grant
  - `llc_ro[1:0]`: proxy idle
  - `llc_so[1:0]`: proxy reply valid

## Operation
- Header fields:
  - [63] VC, [62] Dx, [61] Dy, [60:56] reserved
  - [55:52] Hx, [51:48] Hy, [47:40] SrcX, [39:32] SrcY
  - [31:0] opaque payload
  - Hy and SrcY are ignored.
- Target select: Hx<2 selects LLC0; Hx≥2 selects LLC1.
- Inject buffer: one entry per router.
  - `l0_in_ri[i]` = ~`l0_cv_so[i]`.
  - On `g_in_si[i]`, the buffer captures the flit and sets `l0_cv_so[i]`.
- Request arbitration: per LLC, fixed priority with the lowest router index winning.
  - `l0_cv_ro[i]` is high when the target LLC is IDLE and i is the lowest full buffer targeting it.
  - A granted buffer clears on that edge, and the proxy latches the flit.
- Proxy FSM, two states:
  - IDLE: `llc_ro`=1.
  - BUSY: beat counter 0..1, `llc_so`=1.
  - Transitions: IDLE→BUSY on grant. In BUSY the counter advances on each accepted beat. After beat 1 is accepted the proxy returns to IDLE.
- Reply beat k = latched request with bit 60 set (reply flag), bit 56 = k, and all other bits unchanged.
- Reply destination is router SrcX[1:0].
- Output buffer: one entry per router.
  - ready = ~`l0_out_so[i]` | `l0_out_ro[i]`.
  - If both proxies target the same router in the same cycle, LLC0 wins and LLC1 holds its beat.
- `l0_out_so`/`l0_out_do` are driven directly from the output buffer. A buffer entry pops on valid&ready.

## Timing
- Reset: all buffers empty, both proxies IDLE, beat counters 0.
  - Output values: `l0_in_ri`=4'b1111, `l0_out_so`=0, `l0_out_do`=0, `llc_ro`=2'b11, `llc_so`=0.
- Uncontended latency, for a request accepted at edge t:
  - `l0_cv_so` is high after edge t; grant is in the same cycle.
  - The proxy latches at t+1.
  - Beat 0 is in the output buffer after t+2 and beat 1 after t+3, provided `out_ro`=1.
- The next request is accepted into the same inject buffer no earlier than t+2.
- The proxy is IDLE again after t+3.
- Back-pressure: if `out_ro` is low, the beat stays in the output buffer and the proxy stalls in BUSY. No beat is ever dropped or duplicated.
- Reset asserted mid-burst aborts the burst. No partial state survives.

## Structure
- Shared package holds:
  - header bit positions
  - BURST=2
  - LLC X coordinates {0,3}
  - the Hx threshold
  - the reply-flag bit position
- One natural sub-module, `llc_proxy`, instantiated twice. It contains the FSM, the latch and beat generation.
- The top level holds the inject buffers, the arbiters and the output buffers.

## Test plan
- Single request: router0 sends Hx=0, SrcX=0, payload 0xDEAD0000 as a one-cycle pulse.
  - `l0_out_so[0]` pulses on 2 consecutive cycles, starting 2 cycles after acceptance.
  - Data = request | bit60 for beat 0, with bit56=1 added for beat 1.
  - No other router sees a reply.
- Parallel requests: in the same cycle, router0 sends Hx=0/SrcX=0 and router1 sends Hx=3/SrcX=1.
  - Each router gets exactly 2 replies, at identical latencies, with no interference.
- Contention: routers 0, 1 and 2 all send Hx=0 in the same cycle.
  - Service order is 0, 1, 2.
  - Each router receives 2 beats; the bursts are 2 cycles apart.
- Back-pressure: `l0_out_ro[0]`=0 for 5 cycles during a burst.
  - `l0_out_so[0]` holds beat 0 stable.
  - Both beats arrive after the release; the total count is 2.
- Output collision: router2 sends to LLC0 and router3 sends to LLC1, both with SrcX=0, in the same cycle.
  - Router0 receives 4 beats with LLC0 beats first.
- Reset during a burst, then a fresh request: outputs return to their reset values, and the new request yields exactly 2 beats.
